// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with don't-care mask and saturating match count
//
// Purpose: shifts in one qualified bit per clock (MSB-first), compares the most
// recent PAT_WIDTH bits against a runtime-loadable pattern under a per-bit
// compare mask, and emits a registered one-cycle pulse per match. Overlapping
// or non-overlapping detection is selected at runtime.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     in_bit is sampled this cycle
//   in_bit       serial data bit
//   cfg_load     latch cfg_pattern / cfg_mask / cfg_overlap, restart the window
//   cfg_pattern  pattern, MSB compared against the oldest bit
//   cfg_mask     1 = compare bit, 0 = don't care
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clear    synchronous clear of match_count
//   detect       registered one-cycle match pulse
//   match_count  saturating match counter
//   fill         number of valid bits currently in the history window
module seq_detector_param #(
    parameter int PAT_WIDTH = 4,
    parameter int CNT_WIDTH = 8,
    parameter int FILL_W    = $clog2(PAT_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 cfg_load,
    input  logic [PAT_WIDTH-1:0] cfg_pattern,
    input  logic [PAT_WIDTH-1:0] cfg_mask,
    input  logic                 cfg_overlap,
    input  logic                 cnt_clear,
    output logic                 detect,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [FILL_W-1:0]    fill
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_WIDTH);

    logic [PAT_WIDTH-1:0] hist_q, hist_d;
    logic [PAT_WIDTH-1:0] pat_q;
    logic [PAT_WIDTH-1:0] msk_q;
    logic                 ovl_q;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_inc;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 det_q;
    logic                 accept;
    logic                 match;

    always_comb begin
        // cfg_load wins over in_valid: a bit arriving with a reload is dropped
        accept   = in_valid && !cfg_load;
        hist_d   = {hist_q[PAT_WIDTH-2:0], in_bit};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);

        // Match is judged on the window as it will look after this shift
        match = accept && (fill_inc == FULL) && (&((hist_d ~^ pat_q) | ~msk_q));

        fill_d = fill_q;
        if (cfg_load) begin
            fill_d = '0;
        end else if (accept) begin
            // Non-overlap mode restarts the window so the next match needs
            // PAT_WIDTH fresh bits
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end

        // Clear first, then count, so a same-cycle clear and match leaves 1
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end
        if (match && !(&cnt_d)) begin
            cnt_d = cnt_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            msk_q  <= '1;
            ovl_q  <= 1'b1;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                msk_q <= cfg_mask;
                ovl_q <= cfg_overlap;
            end
            if (accept) begin
                hist_q <= hist_d;
            end
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            det_q  <= match;
        end
    end

    assign detect      = det_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int PW = 4;
    localparam int FW = $clog2(PW + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_bit;
    logic          cfg_load;
    logic [PW-1:0] cfg_pattern;
    logic [PW-1:0] cfg_mask;
    logic          cfg_overlap;
    logic          cnt_clear;

    logic          detect_a, detect_b;
    logic [7:0]    count_a;
    logic [1:0]    count_b;
    logic [FW-1:0] fill_a, fill_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: window value, bits held, config, unbounded match tally
    int m_hist, m_fill, m_pat, m_msk, m_ovl, m_raw, m_det;

    seq_detector_param #(.PAT_WIDTH(PW), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detect(detect_a), .match_count(count_a), .fill(fill_a)
    );

    seq_detector_param #(.PAT_WIDTH(PW), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detect(detect_b), .match_count(count_b), .fill(fill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cnt(input int max);
        return (m_raw > max) ? max : m_raw;
    endfunction

    task automatic model_reset();
        m_hist = 0; m_fill = 0; m_pat = 0; m_msk = 15; m_ovl = 1; m_raw = 0; m_det = 0;
    endtask

    // Applies one cycle of inputs, waits past the edge, advances the model
    task automatic drive(input bit v, input bit b, input bit ld, input int pat,
                         input int msk, input bit ov, input bit clr);
        bit hit;
        in_valid    = v;
        in_bit      = b;
        cfg_load    = ld;
        cfg_pattern = pat[PW-1:0];
        cfg_mask    = msk[PW-1:0];
        cfg_overlap = ov;
        cnt_clear   = clr;
        @(posedge clk);
        #1;
        hit   = 1'b0;
        m_det = 0;
        if (ld) begin
            m_pat  = pat % 16;
            m_msk  = msk % 16;
            m_ovl  = ov;
            m_fill = 0;
        end else if (v) begin
            m_hist = (m_hist * 2 + b) % 16;
            if (m_fill < PW) m_fill++;
            if (m_fill == PW) begin
                hit = 1'b1;
                for (int i = 0; i < PW; i++) begin
                    if (((m_msk >> i) % 2 == 1) && ((m_hist >> i) % 2 != (m_pat >> i) % 2))
                        hit = 1'b0;
                end
            end
            if (hit) begin
                m_det = 1;
                if (m_ovl == 0) m_fill = 0;
            end
        end
        if (clr) m_raw = hit ? 1 : 0;
        else if (hit) m_raw++;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic bit_in(input bit b);
        drive(1'b1, b, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input int pat, input int msk, input bit ov);
        drive(1'b0, 1'b0, 1'b1, pat, msk, ov, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (detect_a !== 1'b0) begin n_fail++; $display("FAIL reset_detect: got %0b expected 0", detect_a); end
        n_checks++;
        if (count_a !== 8'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d expected 0", count_a); end
        n_checks++;
        if (count_b !== 2'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", count_b); end
        n_checks++;
        if (fill_a !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_a); end
    endtask

    task automatic test_overlap();
        bit seq[7]   = '{1, 0, 1, 1, 0, 1, 1};
        bit pulse[7] = '{0, 0, 0, 1, 0, 0, 1};
        drive(1'b0, 1'b0, 1'b1, 11, 15, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bit_in(seq[i]);
            n_checks++;
            if (detect_a !== pulse[i]) begin
                n_fail++; $display("FAIL overlap_detect bit %0d: got %0b expected %0b", i + 1, detect_a, pulse[i]);
            end
        end
        n_checks++;
        if (count_a !== 8'd2) begin n_fail++; $display("FAIL overlap_count: got %0d expected 2", count_a); end
    endtask

    task automatic test_nonoverlap();
        bit seq1[7]   = '{1, 0, 1, 1, 0, 1, 1};
        bit pulse1[7] = '{0, 0, 0, 1, 0, 0, 0};
        bit seq2[8]   = '{1, 0, 1, 1, 1, 0, 1, 1};
        bit pulse2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        drive(1'b0, 1'b0, 1'b1, 11, 15, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bit_in(seq1[i]);
            n_checks++;
            if (detect_a !== pulse1[i]) begin
                n_fail++; $display("FAIL nonovl_detect bit %0d: got %0b expected %0b", i + 1, detect_a, pulse1[i]);
            end
        end
        n_checks++;
        if (fill_a !== FW'(3)) begin n_fail++; $display("FAIL nonovl_fill: got %0d expected 3", fill_a); end
        n_checks++;
        if (count_a !== 8'd1) begin n_fail++; $display("FAIL nonovl_count1: got %0d expected 1", count_a); end
        do_reset();
        load(11, 15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_in(seq2[i]);
            n_checks++;
            if (detect_a !== pulse2[i]) begin
                n_fail++; $display("FAIL nonovl2_detect bit %0d: got %0b expected %0b", i + 1, detect_a, pulse2[i]);
            end
        end
        n_checks++;
        if (count_a !== 8'd2) begin n_fail++; $display("FAIL nonovl_count2: got %0d expected 2", count_a); end
    endtask

    task automatic test_mask();
        bit seq_hit[4]  = '{1, 1, 1, 1};
        bit seq_miss[4] = '{1, 1, 1, 0};
        do_reset();
        load(9, 9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(seq_hit[i]);
            n_checks++;
            if (detect_a !== (i == 3)) begin
                n_fail++; $display("FAIL mask_hit bit %0d: got %0b expected %0b", i + 1, detect_a, (i == 3));
            end
        end
        do_reset();
        load(9, 9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(seq_miss[i]);
            n_checks++;
            if (detect_a !== 1'b0) begin
                n_fail++; $display("FAIL mask_miss bit %0d: got %0b expected 0", i + 1, detect_a);
            end
        end
        n_checks++;
        if (count_a !== 8'd0) begin n_fail++; $display("FAIL mask_count: got %0d expected 0", count_a); end
    endtask

    task automatic test_saturation();
        do_reset();
        load(0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bit_in(1'($urandom_range(0, 1)));
            n_checks++;
            if (detect_b !== (i >= 3)) begin
                n_fail++; $display("FAIL sat_detect bit %0d: got %0b expected %0b", i + 1, detect_b, (i >= 3));
            end
        end
        n_checks++;
        if (count_b !== 2'd3) begin n_fail++; $display("FAIL sat_count_b6: got %0d expected 3", count_b); end
        bit_in(1'b0);
        bit_in(1'b1);
        n_checks++;
        if (count_b !== 2'd3) begin n_fail++; $display("FAIL sat_hold_b: got %0d expected 3", count_b); end
        n_checks++;
        if (count_a !== 8'd5) begin n_fail++; $display("FAIL sat_count_a: got %0d expected 5", count_a); end
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0, 1'b1);
        n_checks++;
        if (detect_a !== 1'b1) begin n_fail++; $display("FAIL clr_detect: got %0b expected 1", detect_a); end
        n_checks++;
        if (count_a !== 8'd1 || count_b !== 2'd1) begin
            n_fail++; $display("FAIL clr_with_match: got a=%0d b=%0d expected 1", count_a, count_b);
        end
    endtask

    task automatic test_abort();
        do_reset();
        load(11, 15, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (detect_a !== 1'b0 || count_a !== 8'd0 || fill_a !== '0) begin
            n_fail++; $display("FAIL abort_rst_outputs: got det=%0b cnt=%0d fill=%0d expected 0", detect_a, count_a, fill_a);
        end
        model_reset();
        rst_n = 1'b1;
        load(11, 15, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        drive(1'b1, 1'b1, 1'b1, 11, 15, 1'b1, 1'b0);
        n_checks++;
        if (fill_a !== '0 || detect_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_load_discard: got fill=%0d det=%0b expected 0 0", fill_a, detect_a);
        end
        bit_in(1'b1);
        n_checks++;
        if (fill_a !== FW'(1) || detect_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_after_load: got fill=%0d det=%0b expected 1 0", fill_a, detect_a);
        end
        do_reset();
        bit_in(1'b1);
        n_checks++;
        if (fill_a !== FW'(1) || detect_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_after_rst: got fill=%0d det=%0b expected 1 0", fill_a, detect_a);
        end
    endtask

    task automatic test_gapped();
        bit seq[4] = '{1, 0, 1, 1};
        int pulses = 0;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 11, 15, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                idle();
                if (detect_a) pulses++;
            end
            bit_in(seq[i]);
            if (detect_a) pulses++;
        end
        n_checks++;
        if (detect_a !== 1'b1) begin n_fail++; $display("FAIL gapped_final_pulse: got %0b expected 1", detect_a); end
        idle();
        if (detect_a) pulses++;
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL gapped_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r = $urandom_range(0, 99);
            if (r < 4) begin
                int mk = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
                drive(1'b0, 1'b0, 1'b1, $urandom_range(0, 15), mk, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 30) == 0));
            end else begin
                drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0,
                      1'($urandom_range(0, 30) == 0));
            end
            n_checks++;
            if (detect_a !== 1'(m_det) || count_a !== 8'(exp_cnt(255)) || count_b !== 2'(exp_cnt(3))
                || fill_a !== FW'(m_fill) || detect_b !== 1'(m_det)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got det=%0b cnt_a=%0d cnt_b=%0d fill=%0d expected det=%0d cnt_a=%0d cnt_b=%0d fill=%0d",
                         c, detect_a, count_a, count_b, fill_a, m_det, exp_cnt(255), exp_cnt(3), m_fill);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        cfg_overlap = 1'b0;
        cnt_clear   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_overlap();
        test_nonoverlap();
        test_mask();
        test_saturation();
        test_abort();
        test_gapped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector for the sequence-detector datapath. It consumes one qualified input bit per clock, MSB-first, and compares the most recent `PAT_WIDTH` bits against a runtime-loadable pattern with a per-bit don't-care mask. It flags each match with a registered one-cycle pulse and keeps a saturating match count. Overlapping or non-overlapping detection is selectable at runtime. It replaces fixed-pattern, fixed-mode detectors and sits between the serialiser and the result-collection logic.

## Interface
- `PAT_WIDTH`, 4: pattern length in bits, 2..16.
- `CNT_WIDTH`, 8: width of match counter.
- `FILL_W`, `$clog2(PAT_WIDTH+1)`: width of fill-level debug output (derived; do not override).

- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_bit` is sampled this cycle.
- `in_bit`  input  1  serial data bit.
- `cfg_load`  input  1  latch `cfg_pattern`/`cfg_mask`/`cfg_overlap` this cycle.
- `cfg_pattern`  input  PAT_WIDTH  pattern; bit PAT_WIDTH-1 is matched against the oldest bit.
- `cfg_mask`  input  PAT_WIDTH  1 = compare bit, 0 = don't care.
- `cfg_overlap`  input  1  1 = overlapping detection, 0 = non-overlapping.
- `cnt_clear`  input  1  synchronous clear of `match_count`.
- `detect`  output  1  one-cycle match pulse (registered).
- `match_count`  output  CNT_WIDTH  saturating number of matches.
- `fill`  output  FILL_W  valid bits currently held in history, 0..PAT_WIDTH (debug).

## Operation
- State: history shift register `hist[PAT_WIDTH-1:0]`, `fill`, config registers `pat`, `msk`, `ovl`, `match_count`, `detect`.
- Reset (`rst_n`=0, immediate): `hist`=0, `fill`=0, `pat`=0, `msk`=all ones, `ovl`=1, `match_count`=0, `detect`=0.
- Accepted bit (`in_valid`=1, `cfg_load`=0): `hist` <= {`hist[PAT_WIDTH-2:0]`, `in_bit`}; `fill` increments, saturating at PAT_WIDTH.
- Match condition, evaluated on the post-shift window: `fill`(new) == PAT_WIDTH and ((new `hist` XNOR `pat`) OR ~`msk`) == all ones.
- On match:
  - `detect` <= 1 next cycle.
  - `match_count` increments, saturating at 2^CNT_WIDTH-1.
  - If `ovl`=0, `fill` <= 0 instead of PAT_WIDTH. The next match then needs PAT_WIDTH fresh bits.
  - If `ovl`=1, `fill` stays PAT_WIDTH, so a match is possible on every subsequent bit.
- Mask all zeros with `fill`=PAT_WIDTH: every accepted bit matches.
- `cfg_load`=1: latch the three config inputs and set `fill` <= 0; `hist` is kept but ignored until refilled. An `in_valid` bit in the same cycle is discarded. `cfg_load` has priority over `in_valid`. `detect` <= 0 that cycle.
- `cnt_clear`=1: `match_count` <= 0. If a match occurs in the same cycle, `match_count` <= 1 (clear then count). `detect` is unaffected.
- `in_valid`=0: no state change except `detect` <= 0. Idle gaps between bits are allowed and do not break a sequence.

## Timing
- Latency: a bit sampled at edge N raises `detect` during cycle N..N+1, visible after edge N. `match_count` updates at the same edge.
- `detect` is high exactly one cycle per match. Back-to-back matches in overlap mode give consecutive high cycles.
- Throughput: one bit per clock, no stalls, no backpressure.
- Asynchronous assertion of `rst_n` mid-sequence aborts partial matches. Deassertion is synchronised externally; the first edge after release may accept a bit.
- Config changes take effect for bits accepted on the cycle after `cfg_load`.

## Test plan
- Overlap mode, `PAT_WIDTH`=4, pattern 1011, mask 1111, bits 1,0,1,1,0,1,1 on consecutive cycles -> `detect` pulses after bits 4 and 7; `match_count`=2.
- Non-overlap mode, same pattern, bits 1,0,1,1,0,1,1 -> single pulse after bit 4, `fill`=3 at end. Then bits 1,0,1,1,1,0,1,1 from reset -> pulses after bits 4 and 8.
- Mask: pattern 1001, mask 1001, bits 1,1,1,1 -> pulse after bit 4. Bits 1,1,1,0 -> no pulse.
- Saturation and clear: `CNT_WIDTH`=2, mask 0000, 6 accepted bits -> 3 pulses counted, `match_count` holds 3. `cnt_clear` asserted concurrently with a match -> `match_count`=1.
- Reset and config abort: 3 bits of 1011 sent, then `rst_n` pulsed low -> all outputs 0. Next bit 1 -> no pulse, `fill`=1. Repeat with `cfg_load` plus concurrent `in_valid` instead of reset -> that bit is discarded, `fill`=0.
- Gapped input: bits 1,0,1,1 separated by 0-3 random idle cycles -> exactly one pulse, one cycle after the final bit's edge.
